// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared state type and byte-lane helpers for the header inserter
package axis_hdr_pkg;

   localparam int MAX_BYTES = 64;
   localparam int MAX_BITS  = MAX_BYTES * 8;

   typedef logic [MAX_BITS-1:0]  wide_t;
   typedef logic [MAX_BYTES-1:0] lanes_t;

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   function automatic logic [7:0] popcount(input lanes_t keep);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < MAX_BYTES; i++) c = c + {7'd0, keep[i]};
      return c;
   endfunction

   // Lanes [w-1 : w-n] set: the first n bytes on the wire of a w-byte beat.
   function automatic lanes_t msb_mask(input logic [7:0] n, input logic [7:0] w);
      lanes_t m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (i < int'(w) && i >= int'(w) - int'(n)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic lanes_t lsb_mask(input logic [7:0] n);
      lanes_t m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (i < int'(n)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic wide_t lane_bits(input lanes_t m);
      wide_t b;
      b = '0;
      for (int i = 0; i < MAX_BYTES; i++) b[i*8 +: 8] = {8{m[i]}};
      return b;
   endfunction

   // {residue (h bytes), top w-h bytes of data} within a w-byte beat
   function automatic wide_t merge(input wide_t residue, input wide_t data,
                                   input logic [7:0] h, input logic [7:0] w);
      return (residue << ((int'(w) - int'(h)) * 8)) | (data >> (int'(h) * 8));
   endfunction

endpackage

// File: rtl/axis_hdr_insert_pipe_out_reg.sv
// rtl/axis_hdr_insert_pipe_out_reg.sv - single output register slice with load-when-empty-or-drained rule
module axis_out_reg #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    beat_vld,
   input  logic [DATA_WD-1:0]      beat_data,
   input  logic [DATA_BYTE_WD-1:0] beat_keep,
   input  logic                    beat_last,
   input  logic                    ready_out,
   output logic                    ld,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out
);

   assign ld = ~valid_out | ready_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else if (ld) begin
         valid_out <= beat_vld;
         data_out  <= beat_vld ? beat_data : '0;
         keep_out  <= beat_vld ? beat_keep : '0;
         last_out  <= beat_vld & beat_last;
      end
   end

endmodule

// File: rtl/axis_hdr_insert_pipe.sv
// rtl/axis_hdr_insert_pipe.sv - prepends 0..W header bytes to each packet at one beat per clock
module axis_hdr_insert_pipe
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int HDR_CNT_WD   = $clog2(DATA_BYTE_WD + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [HDR_CNT_WD-1:0]   hdr_cnt,
   output logic                    ready_insert,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out
);

   localparam logic [7:0] W8 = 8'(DATA_BYTE_WD);

   logic rst_meta_n, rst_sync_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {rst_sync_n, rst_meta_n} <= 2'b00;
      else        {rst_sync_n, rst_meta_n} <= {rst_meta_n, 1'b1};
   end

   state_t                  state;
   logic [HDR_CNT_WD-1:0]   h_q, l_q, h_new;
   logic [DATA_WD-1:0]      residue_q, src;
   logic                    ld, acc_in, beat_vld, beat_last, keep_contig;
   logic [DATA_WD-1:0]      beat_data;
   logic [DATA_BYTE_WD-1:0] beat_keep;
   logic [7:0]              h8, l8, sum8;

   assign ready_insert = (state == IDLE);
   assign ready_in     = (state == STREAM) && ld;
   assign acc_in       = valid_in && ready_in;
   assign h_new        = (hdr_cnt > HDR_CNT_WD'(DATA_BYTE_WD)) ? HDR_CNT_WD'(DATA_BYTE_WD) : hdr_cnt;

   always_comb begin
      h8        = 8'(h_q);
      l8        = popcount(lanes_t'(keep_in));
      sum8      = h8 + l8;
      beat_vld  = 1'b0;
      beat_last = 1'b0;
      beat_keep = '1;
      src       = data_in;
      case (state)
         STREAM: begin
            beat_vld = acc_in;
            if (last_in && sum8 <= W8) begin
               beat_keep = DATA_BYTE_WD'(msb_mask(sum8, W8));
               beat_last = 1'b1;
            end
         end
         FLUSH: begin
            beat_vld  = 1'b1;
            src       = '0;
            beat_keep = DATA_BYTE_WD'(msb_mask(h8 + 8'(l_q) - W8, W8));
            beat_last = 1'b1;
         end
         default: ;
      endcase
      // Lanes outside keep are forced to zero, including stale residue bytes.
      beat_data = DATA_WD'(merge(wide_t'(residue_q), wide_t'(src), h8, W8)
                           & lane_bits(lanes_t'(beat_keep)));
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state     <= IDLE;
         h_q       <= '0;
         l_q       <= '0;
         residue_q <= '0;
      end else begin
         case (state)
            IDLE: if (valid_insert) begin
               h_q       <= h_new;
               residue_q <= DATA_WD'(wide_t'(data_insert) & lane_bits(lsb_mask(8'(h_new))));
               state     <= STREAM;
            end
            STREAM: if (acc_in) begin
               residue_q <= DATA_WD'(wide_t'(data_in) & lane_bits(lsb_mask(h8)));
               if (last_in) begin
                  l_q   <= HDR_CNT_WD'(l8);
                  state <= (sum8 <= W8) ? IDLE : FLUSH;
               end
            end
            FLUSH: if (ld) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   axis_out_reg #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_sync_n),
      .beat_vld  (beat_vld),
      .beat_data (beat_data),
      .beat_keep (beat_keep),
      .beat_last (beat_last),
      .ready_out (ready_out),
      .ld        (ld),
      .valid_out (valid_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out)
   );

   assign keep_contig = (keep_in == DATA_BYTE_WD'(msb_mask(l8, W8)));

   assert property (@(posedge clk) disable iff (!rst_sync_n) (acc_in && last_in) |-> keep_contig);

endmodule

// File: tb/tb_axis_hdr_insert_pipe.sv
// tb/tb_axis_hdr_insert_pipe.sv - directed and stalled-sink checks of axis_hdr_insert_pipe against a byte-stream model
module tb_axis_hdr_insert_pipe;

   localparam int W  = 4;
   localparam int DW = 32;
   localparam int HW = 3;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          valid_in = 1'b0, last_in = 1'b0, ready_in;
   logic [DW-1:0] data_in = '0;
   logic [W-1:0]  keep_in = '0;
   logic          valid_insert = 1'b0, ready_insert;
   logic [DW-1:0] data_insert = '0;
   logic [HW-1:0] hdr_cnt = '0;
   logic          valid_out, last_out, ready_out = 1'b1;
   logic [DW-1:0] data_out;
   logic [W-1:0]  keep_out;

   axis_hdr_insert_pipe #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
      .valid_insert(valid_insert), .data_insert(data_insert), .hdr_cnt(hdr_cnt), .ready_insert(ready_insert),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_out(ready_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic last; logic [W-1:0] keep; logic [DW-1:0] data;} beat_t;

   beat_t         exp_q[$];
   beat_t         mdl_q[$];
   logic [DW-1:0] pay [16];
   int            total = 0, bad = 0, cyc = 0, first_acc = 0;
   int            out_cyc[$];
   bit            mon_en = 0, rand_mode = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Output = header bytes (first on wire = highest valid header byte) then payload bytes, chopped into W-byte beats.
   task automatic model(input int hc, input logic [DW-1:0] hdr, input int nb, input int lastl);
      logic [7:0] bq[$];
      int         h, idx, n;
      beat_t      b;
      mdl_q.delete();
      h = (hc > W) ? W : hc;
      for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
      for (int k = 0; k < nb; k++) begin
         n = (k == nb - 1) ? lastl : W;
         for (int i = 0; i < n; i++) bq.push_back(pay[k][(W-1-i)*8 +: 8]);
      end
      idx = 0;
      while (idx < bq.size()) begin
         b = '0;
         for (int j = 0; j < W && idx < bq.size(); j++) begin
            b.data[(W-1-j)*8 +: 8] = bq[idx];
            b.keep[W-1-j] = 1'b1;
            idx++;
         end
         b.last = (idx == bq.size());
         mdl_q.push_back(b);
      end
   endtask

   task automatic send_hdr(input int hc, input logic [DW-1:0] hdr);
      int n = 0;
      valid_insert = 1'b1;
      data_insert  = hdr;
      hdr_cnt      = HW'(hc);
      do begin @(negedge clk); n++; end while (!ready_insert && n < 300);
      chk("hdr_accept", ready_insert, 1);
      @(posedge clk); #1;
      valid_insert = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic last, input int l, output int acc);
      int n = 0;
      logic [W-1:0] all1 = '1;
      valid_in = 1'b1;
      data_in  = d;
      last_in  = last;
      keep_in  = last ? ~(all1 >> l) : 4'b0101;
      do begin @(negedge clk); n++; end while (!ready_in && n < 300);
      chk("beat_accept", ready_in, 1);
      acc = cyc;
      @(posedge clk); #1;
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic send_packet(input int hc, input logic [DW-1:0] hdr, input int nb, input int lastl);
      int acc;
      model(hc, hdr, nb, lastl);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      send_hdr(hc, hdr);
      for (int k = 0; k < nb; k++) begin
         send_beat(pay[k], k == nb - 1, lastl, acc);
         if (k == 0) first_acc = acc;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
      repeat (3) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      ready_out = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   beat_t held;
   bit    stall_prev = 0;

   initial forever begin
      @(negedge clk);
      if (!mon_en) stall_prev = 0;
      else begin
         if (stall_prev) chk("stall_hold", {valid_out, last_out, keep_out, data_out}, {1'b1, held});
         if (valid_out && ready_out) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_beat: got %h expected none", {last_out, keep_out, data_out});
            end else chk("out_beat", {last_out, keep_out, data_out}, exp_q.pop_front());
         end
         stall_prev = valid_out && !ready_out;
         held = {last_out, keep_out, data_out};
      end
   end

   initial begin
      int acc, hc, nb, l;
      logic [DW-1:0] hdr;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_keep_out", keep_out, 0);
      chk("rst_last_out", last_out, 0);
      chk("rst_ready_in", ready_in, 0);
      chk("rst_ready_insert", ready_insert, 1);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      mon_en = 1;

      pay[0] = 32'h11223344; pay[1] = 32'h55667788;
      model(2, 32'hAABBCCDD, 2, 4);
      chk("t1_nbeats", mdl_q.size(), 3);
      chk("t1_b0", mdl_q[0], {1'b0, 4'b1111, 32'hCCDD1122});
      chk("t1_b1", mdl_q[1], {1'b0, 4'b1111, 32'h33445566});
      chk("t1_b2", mdl_q[2], {1'b1, 4'b1100, 32'h77880000});
      send_packet(2, 32'hAABBCCDD, 2, 4);
      drain();

      pay[0] = 32'h11223344;
      model(2, 32'hAABBCCDD, 1, 2);
      chk("t2_nbeats", mdl_q.size(), 1);
      chk("t2_b0", mdl_q[0], {1'b1, 4'b1111, 32'hCCDD1122});
      send_packet(2, 32'hAABBCCDD, 1, 2);
      drain();

      pay[0] = 32'h01020304; pay[1] = 32'h05060708; pay[2] = 32'h090A0B0C;
      model(0, 32'hDEADBEEF, 3, 3);
      chk("t3_b2", mdl_q[2], {1'b1, 4'b1110, 32'h090A0B00});
      out_cyc.delete();
      send_packet(0, 32'hDEADBEEF, 3, 3);
      drain();
      chk("t3_nbeats", out_cyc.size(), 3);
      if (out_cyc.size() == 3) begin
         chk("t3_no_bubble", out_cyc[2] - out_cyc[0], 2);
         chk("t3_latency", out_cyc[0] - first_acc, 1);
      end

      pay[0] = 32'h11223344;
      model(4, 32'hAABBCCDD, 1, 1);
      chk("t4_nbeats", mdl_q.size(), 2);
      chk("t4_b0", mdl_q[0], {1'b0, 4'b1111, 32'hAABBCCDD});
      chk("t4_b1", mdl_q[1], {1'b1, 4'b1000, 32'h11000000});
      send_packet(4, 32'hAABBCCDD, 1, 1);
      drain();

      pay[0] = 32'hA1A2A3A4;
      model(7, 32'h12345678, 1, 4);
      chk("clip_b0", mdl_q[0], {1'b0, 4'b1111, 32'h12345678});
      send_packet(7, 32'h12345678, 1, 4);
      drain();

      rand_mode = 1;
      for (int p = 0; p < 50; p++) begin
         hc  = $urandom_range(0, 7);
         nb  = $urandom_range(1, 4);
         l   = $urandom_range(1, 4);
         hdr = $urandom;
         for (int k = 0; k < nb; k++) pay[k] = $urandom;
         send_packet(hc, hdr, nb, l);
      end
      drain();
      rand_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      mon_en = 0;
      pay[0] = 32'h10203040; pay[1] = 32'h50607080;
      send_hdr(2, 32'h0000BEEF);
      send_beat(pay[0], 1'b0, 4, acc);
      valid_in = 1'b1;
      data_in  = pay[1];
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid_out", valid_out, 0);
      chk("rst_mid_ready_in", ready_in, 0);
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_valid_out", valid_out, 0);
      chk("post_rst_ready_insert", ready_insert, 1);
      exp_q.delete();
      mon_en = 1;
      pay[0] = 32'hC1C2C3C4; pay[1] = 32'hD1D2D3D4;
      model(3, 32'h00E1E2E3, 2, 2);
      chk("t6_b2", mdl_q[2], {1'b1, 4'b1000, 32'hD2000000});
      send_packet(3, 32'h00E1E2E3, 2, 2);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
